// File: rtl/uart_pkg.sv
// Shared UART definitions: 3-bit state encoding (common to transmitter and receiver)
// and frame bit counts.
package uart_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_STOP    = 3'd4;
  localparam logic [2:0] ST_CLEANUP = 3'd5;

  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS     = 10;
  localparam int FRAME_BITS_PAR = 11;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-cycle counter: counts 0..CLKS_PER_BIT-1 while enabled and strobes bit_end on the
// last cycle of each bit; zero latency, no backpressure, held at zero while disabled.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_end
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, optional parity bit when UART_TX_PARITY_EN is defined.
// Start bit 1 cycle after accept; one byte held behind the frame, o_Tx_Ready low while it is full.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    START   = ST_START,
    DATA    = ST_DATA,
`ifdef UART_TX_PARITY_EN
    PARITY  = ST_PARITY,
`endif
    STOP    = ST_STOP,
    CLEANUP = ST_CLEANUP
  } state_e;

  state_e     state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       hold_full;
  logic [7:0] hold_byte;
  logic [7:0] load_byte;
  logic       accept;
  logic       cnt_en;
  logic       bit_end;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic par_bit;
`endif

  assign o_Tx_Ready = !hold_full;
  assign accept     = i_Tx_DV && !hold_full;
  // A full holding register always wins over a fresh byte; Ready is low then anyway.
  assign load_byte  = hold_full ? hold_byte : i_Tx_Byte;

`ifdef UART_TX_PARITY_EN
  assign cnt_en = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
`else
  assign cnt_en = (state == START) || (state == DATA) || (state == STOP);
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .en     (cnt_en),
    .bit_end(bit_end)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_idx     <= '0;
      hold_full   <= 1'b0;
      hold_byte   <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      o_Tx_Done <= 1'b0;
      if (accept && (state != IDLE)) begin
        hold_full <= 1'b1;
        hold_byte <= i_Tx_Byte;
      end
      case (state)
        IDLE: begin
          if (hold_full || i_Tx_DV) begin
            shreg       <= load_byte;
            hold_full   <= 1'b0;
            state       <= START;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit     <= (^load_byte) ^ PAR_SENSE;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state       <= DATA;
            o_Tx_Serial <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx     <= '0;
`ifdef UART_TX_PARITY_EN
              state       <= PARITY;
              o_Tx_Serial <= par_bit;
`else
              state       <= STOP;
              o_Tx_Serial <= 1'b1;
`endif
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              shreg       <= {1'b0, shreg[7:1]};
              o_Tx_Serial <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state       <= STOP;
            o_Tx_Serial <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            o_Tx_Done <= 1'b1;
            // Back-to-back: the held byte's start bit follows the stop bit directly.
            if (hold_full) begin
              shreg       <= hold_byte;
              hold_full   <= 1'b0;
              state       <= START;
              o_Tx_Serial <= 1'b0;
`ifdef UART_TX_PARITY_EN
              par_bit     <= (^hold_byte) ^ PAR_SENSE;
`endif
            end else begin
              state       <= CLEANUP;
              o_Tx_Active <= 1'b0;
            end
          end
        end
        CLEANUP: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule
